// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snake_pkg
//  Description : Shared encodings for the snake game: movement directions,
//                game states, score limits and a reverse-direction helper.
//                Used by the game sequencer and the snake drawing block.
//  Revision    : 1.0  initial release
// ============================================================================
package snake_pkg;

    typedef enum logic [2:0] {
        DIR_IDLE  = 3'b000,
        DIR_UP    = 3'b001,
        DIR_DOWN  = 3'b010,
        DIR_LEFT  = 3'b011,
        DIR_RIGHT = 3'b100
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_PLAY      = 2'b01,
        ST_PAUSE     = 2'b10,
        ST_GAME_OVER = 2'b11
    } game_state_t;

    localparam int         c_SCORE_W   = 8;
    localparam logic [7:0] c_SCORE_MAX = 8'hFF;

    // Direction that would make the snake turn back onto its own neck.
    function automatic dir_t opposite_dir(input dir_t d);
        dir_t r;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            default:   r = DIR_IDLE;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_move_timer.sv
`default_nettype none
// ============================================================================
//  Module      : snake_move_timer
//  Description : Divides frame_tick by DIV. fire is high (combinationally) on
//                the tick that completes a group of DIV enabled ticks; the
//                caller registers it. clear has priority and zeroes the count;
//                with enable low the count is frozen.
//  Revision    : 1.0  initial release
// ============================================================================
module snake_move_timer #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic fire
);

    localparam logic [7:0] c_LAST = 8'(DIV - 1);

    logic [7:0] r_count;
    logic       w_last;

    assign w_last = (r_count == c_LAST);
    assign fire   = enable & tick & w_last & ~clear;

    // Tick counter that wraps after DIV enabled ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && tick) begin
            r_count <= w_last ? 8'd0 : r_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/snake_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : snake_game_ctrl
//  Description : Snake game sequencer. Converts button edges and frame ticks
//                into direction / update / game_state, detects wall and self
//                collisions and keeps the food score.
//                Optional pause support: define SNAKE_GAME_PAUSE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int BIT             = 10,
    parameter int SIZE            = 5,
    parameter int X_MAX           = 640,
    parameter int Y_MAX           = 480,
    parameter int FRAME_DIV       = 8,
    parameter int GAMEOVER_FRAMES = 60
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           frame_tick,
    input  logic           btn_up,
    input  logic           btn_down,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic           btn_pause,
    input  logic [BIT-1:0] head_x,
    input  logic [BIT-1:0] head_y,
    input  logic           food_hit,
    input  logic           self_hit,
    output logic [2:0]     direction,
    output logic [1:0]     game_state,
    output logic           update,
    output logic [7:0]     score
);

    localparam logic [BIT-1:0] c_X_LIM = BIT'(X_MAX - SIZE);
    localparam logic [BIT-1:0] c_Y_LIM = BIT'(Y_MAX - SIZE);

    game_state_t          r_state;
    dir_t                 r_dir;
    dir_t                 r_pending;
    logic                 r_update;
    logic                 r_check;
    logic [c_SCORE_W-1:0] r_score;
    logic [3:0]           r_btn_prev;

    logic [3:0] w_btn_now;
    logic [3:0] w_btn_rise;
    dir_t       w_press_dir;
    logic       w_pause_rise;
    logic       w_in_play;
    logic       w_collide;
    logic       w_steer_ok;
    logic       w_move_fire;
    logic       w_move_en;
    logic       w_move_clr;
    logic       w_go_fire;
    logic       w_go_active;

    assign w_btn_now  = {btn_up, btn_down, btn_left, btn_right};
    assign w_btn_rise = w_btn_now & ~r_btn_prev;

`ifdef SNAKE_GAME_PAUSE_EN
    logic r_pause_prev;

    // Previous pause level for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pause_prev <= 1'b0;
        end else begin
            r_pause_prev <= btn_pause;
        end
    end

    assign w_pause_rise = btn_pause & ~r_pause_prev;
`else
    logic w_unused_pause;
    assign w_unused_pause = btn_pause;
    assign w_pause_rise   = 1'b0;
`endif

    // Priority encode the new presses: UP > DOWN > LEFT > RIGHT.
    always_comb begin
        w_press_dir = DIR_IDLE;
        if (w_btn_rise[3])      w_press_dir = DIR_UP;
        else if (w_btn_rise[2]) w_press_dir = DIR_DOWN;
        else if (w_btn_rise[1]) w_press_dir = DIR_LEFT;
        else if (w_btn_rise[0]) w_press_dir = DIR_RIGHT;
    end

    assign w_in_play   = (r_state == ST_PLAY);
    // The wall test only runs the cycle after a move, once the head register
    // has taken its new position; underflow wraps high and counts as a hit.
    assign w_collide   = w_in_play &
                         (self_hit | (r_check & ((head_x > c_X_LIM) | (head_y > c_Y_LIM))));
    assign w_steer_ok  = (w_press_dir != DIR_IDLE) && (w_press_dir != opposite_dir(r_dir));

    // A pause press consumes its cycle so no move can commit as we leave PLAY.
    assign w_move_en   = w_in_play & ~w_collide & ~w_pause_rise;
    assign w_move_clr  = ~(w_in_play | (r_state == ST_PAUSE)) | w_collide;
    assign w_go_active = (r_state == ST_GAME_OVER);

    snake_move_timer #(
        .DIV (FRAME_DIV)
    ) u_move_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_move_clr),
        .enable (w_move_en),
        .tick   (frame_tick),
        .fire   (w_move_fire)
    );

    snake_move_timer #(
        .DIV (GAMEOVER_FRAMES)
    ) u_gameover_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (~w_go_active),
        .enable (w_go_active),
        .tick   (frame_tick),
        .fire   (w_go_fire)
    );

    // Game state machine with registered direction, update and score.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_dir      <= DIR_IDLE;
            r_pending  <= DIR_IDLE;
            r_update   <= 1'b0;
            r_check    <= 1'b0;
            r_score    <= '0;
            r_btn_prev <= '0;
        end else begin
            r_btn_prev <= w_btn_now;
            r_update   <= 1'b0;
            r_check    <= r_update;

            case (r_state)
                ST_IDLE: begin
                    if (w_press_dir != DIR_IDLE) begin
                        r_state   <= ST_PLAY;
                        r_dir     <= w_press_dir;
                        r_pending <= w_press_dir;
                        r_score   <= '0;
                    end
                end

                ST_PLAY: begin
                    if (food_hit && (r_score != c_SCORE_MAX)) begin
                        r_score <= r_score + 8'd1;
                    end
                    if (w_collide) begin
                        r_state <= ST_GAME_OVER;
                        r_dir   <= DIR_IDLE;
                    end else begin
                        if (w_pause_rise) begin
                            r_state <= ST_PAUSE;
                        end
                        if (w_steer_ok) begin
                            r_pending <= w_press_dir;
                        end
                        // Commit uses the pending value from before this
                        // cycle's press, so direction is stable with update.
                        if (w_move_fire) begin
                            r_update <= 1'b1;
                            r_dir    <= r_pending;
                        end
                    end
                end

                ST_PAUSE: begin
                    if (w_pause_rise) begin
                        r_state <= ST_PLAY;
                    end
                end

                ST_GAME_OVER: begin
                    if (w_go_fire) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign direction  = r_dir;
    assign game_state = r_state;
    assign update     = r_update;
    assign score      = r_score;

endmodule
`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snake_game_ctrl
//  Description : Self-checking bench for snake_game_ctrl (default parameters).
//                Expected move directions are queued as stimulus is applied
//                and popped by a monitor whenever update pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_snake_game_ctrl;

    localparam logic [2:0] D_IDLE  = 3'b000;
    localparam logic [2:0] D_UP    = 3'b001;
    localparam logic [2:0] D_DOWN  = 3'b010;
    localparam logic [2:0] D_LEFT  = 3'b011;
    localparam logic [2:0] D_RIGHT = 3'b100;
    localparam logic [3:0] B_UP    = 4'b1000;
    localparam logic [3:0] B_DOWN  = 4'b0100;
    localparam logic [3:0] B_LEFT  = 4'b0010;
    localparam logic [3:0] B_RIGHT = 4'b0001;
    localparam logic [3:0] B_NONE  = 4'b0000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       btn_pause = 1'b0;
    logic [9:0] head_x = 10'd100;
    logic [9:0] head_y = 10'd100;
    logic       food_hit = 1'b0;
    logic       self_hit = 1'b0;
    logic [2:0] direction;
    logic [1:0] game_state;
    logic       update;
    logic [7:0] score;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];

    snake_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_pause  (btn_pause),
        .head_x     (head_x),
        .head_y     (head_y),
        .food_hit   (food_hit),
        .self_hit   (self_hit),
        .direction  (direction),
        .game_state (game_state),
        .update     (update),
        .score      (score)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every update pulse must match the next queued move.
    always begin
        @(posedge clk);
        #1;
        if (update === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL upd_unexpected: update=1 state=%b dir=%b, required no update", game_state, direction);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (direction !== e || game_state !== 2'b01) begin
                    errors++;
                    $display("FAIL upd_dir: dir=%b state=%b, required dir=%b state=01", direction, game_state, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    task automatic press(input logic [3:0] b);
        set_btns(b);
        cyc();
        set_btns(B_NONE);
    endtask

    task automatic press_pause();
        btn_pause = 1'b1;
        cyc();
        btn_pause = 1'b0;
        cyc();
    endtask

    task automatic food_pulse(input logic with_self);
        food_hit = 1'b1;
        self_hit = with_self;
        cyc();
        food_hit = 1'b0;
        self_hit = 1'b0;
        cyc();
    endtask

    // n frame ticks two cycles apart; buttons optionally pressed on the last.
    task automatic run_ticks(input int n, input logic [3:0] last_btns,
                             output int fires, output int first_fire);
        fires = 0;
        first_fire = 0;
        for (int i = 1; i <= n; i++) begin
            frame_tick = 1'b1;
            if (i == n) set_btns(last_btns);
            cyc();
            if (update === 1'b1) begin
                fires++;
                if (first_fire == 0) first_fire = i;
            end
            frame_tick = 1'b0;
            set_btns(B_NONE);
            cyc();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cyc();
        cyc();
        checks++;
        if (game_state !== 2'b00 || direction !== D_IDLE || update !== 1'b0 || score !== 8'd0) begin
            errors++;
            $display("FAIL reset: state=%b dir=%b upd=%b score=%0d, required 00 000 0 0", game_state, direction, update, score);
        end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_start();
        press(B_RIGHT);
        checks++;
        if (game_state !== 2'b01 || direction !== D_RIGHT || score !== 8'd0) begin
            errors++;
            $display("FAIL start: state=%b dir=%b score=%0d, required 01 100 0", game_state, direction, score);
        end
    endtask

    task automatic test_move_timing();
        int f, ff;
        exp_q.push_back(D_RIGHT);
        run_ticks(8, B_NONE, f, ff);
        checks++;
        if (f != 1 || ff != 8) begin
            errors++;
            $display("FAIL move1: fires=%0d at tick %0d, required 1 at tick 8", f, ff);
        end
        press(B_UP);
        checks++;
        if (direction !== D_RIGHT) begin
            errors++;
            $display("FAIL dir_hold: dir=%b, required 100 until next move", direction);
        end
        exp_q.push_back(D_UP);
        run_ticks(8, B_NONE, f, ff);
        checks++;
        if (f != 1 || ff != 8) begin
            errors++;
            $display("FAIL move2: fires=%0d at tick %0d, required 1 at tick 8", f, ff);
        end
    endtask

    task automatic test_steering();
        int f, ff;
        press(B_RIGHT);
        exp_q.push_back(D_RIGHT);
        run_ticks(8, B_NONE, f, ff);
        press(B_LEFT);
        exp_q.push_back(D_RIGHT);
        run_ticks(8, B_NONE, f, ff);
        checks++;
        if (direction !== D_RIGHT) begin
            errors++;
            $display("FAIL reverse: dir=%b, required 100", direction);
        end
        press(B_DOWN | B_LEFT);
        exp_q.push_back(D_DOWN);
        run_ticks(8, B_NONE, f, ff);
        checks++;
        if (direction !== D_DOWN) begin
            errors++;
            $display("FAIL priority: dir=%b, required 010", direction);
        end
        exp_q.push_back(D_DOWN);
        run_ticks(8, B_LEFT, f, ff);
        checks++;
        if (direction !== D_DOWN || f != 1) begin
            errors++;
            $display("FAIL same_cycle: dir=%b fires=%0d, required 010 and 1", direction, f);
        end
        exp_q.push_back(D_LEFT);
        run_ticks(8, B_NONE, f, ff);
        checks++;
        if (direction !== D_LEFT) begin
            errors++;
            $display("FAIL next_move: dir=%b, required 011", direction);
        end
    endtask

    task automatic test_wall();
        int f, ff;
        head_x = 10'd635;
        head_y = 10'd475;
        exp_q.push_back(D_LEFT);
        run_ticks(8, B_NONE, f, ff);
        cyc();
        checks++;
        if (game_state !== 2'b01) begin
            errors++;
            $display("FAIL wall_edge: state=%b, required 01 at x=635 y=475", game_state);
        end
        run_ticks(7, B_NONE, f, ff);
        head_x = 10'd640;
        exp_q.push_back(D_LEFT);
        run_ticks(1, B_NONE, f, ff);
        cyc();
        checks++;
        if (game_state !== 2'b11 || direction !== D_IDLE || score !== 8'd0) begin
            errors++;
            $display("FAIL wall_hit: state=%b dir=%b score=%0d, required 11 000 0", game_state, direction, score);
        end
        head_x = 10'd100;
        head_y = 10'd100;
        press(B_RIGHT);
        run_ticks(59, B_NONE, f, ff);
        checks++;
        if (game_state !== 2'b11) begin
            errors++;
            $display("FAIL go_hold: state=%b after 59 ticks, required 11", game_state);
        end
        run_ticks(1, B_NONE, f, ff);
        checks++;
        if (game_state !== 2'b00 || direction !== D_IDLE) begin
            errors++;
            $display("FAIL go_exit: state=%b dir=%b, required 00 000", game_state, direction);
        end
    endtask

    task automatic test_food();
        int f, ff;
        int model;
        press(B_RIGHT);
        model = 0;
        for (int i = 0; i < 3; i++) begin
            food_pulse(1'b0);
            model++;
        end
        checks++;
        if (score !== 8'(model)) begin
            errors++;
            $display("FAIL food3: score=%0d, required %0d", score, model);
        end
        food_hit = 1'b1;
        self_hit = 1'b1;
        cyc();
        food_hit = 1'b0;
        self_hit = 1'b0;
        model++;
        checks++;
        if (game_state !== 2'b11 || direction !== D_IDLE || score !== 8'(model)) begin
            errors++;
            $display("FAIL self_food: state=%b dir=%b score=%0d, required 11 000 %0d", game_state, direction, score, model);
        end
        run_ticks(60, B_NONE, f, ff);
        checks++;
        if (game_state !== 2'b00 || score !== 8'(model)) begin
            errors++;
            $display("FAIL score_held: state=%b score=%0d, required 00 %0d", game_state, score, model);
        end
        press(B_RIGHT);
        checks++;
        if (score !== 8'd0) begin
            errors++;
            $display("FAIL score_clear: score=%0d, required 0", score);
        end
        model = 0;
        for (int i = 1; i <= 300; i++) begin
            food_pulse(1'b0);
            if (model < 255) model++;
            if (i == 100 || i == 300) begin
                checks++;
                if (score !== 8'(model)) begin
                    errors++;
                    $display("FAIL food_sat: after %0d pulses score=%0d, required %0d", i, score, model);
                end
            end
        end
        exp_q.push_back(D_RIGHT);
        run_ticks(7, B_NONE, f, ff);
        head_y = 10'd1023;
        run_ticks(1, B_NONE, f, ff);
        cyc();
        checks++;
        if (game_state !== 2'b11 || score !== 8'd255) begin
            errors++;
            $display("FAIL underflow: state=%b score=%0d, required 11 255", game_state, score);
        end
        head_y = 10'd100;
        run_ticks(60, B_NONE, f, ff);
    endtask

    task automatic test_pause();
        int f, ff;
        press(B_RIGHT);
        run_ticks(3, B_NONE, f, ff);
        press_pause();
`ifdef SNAKE_GAME_PAUSE_EN
        checks++;
        if (game_state !== 2'b10) begin
            errors++;
            $display("FAIL pause_enter: state=%b, required 10", game_state);
        end
        self_hit = 1'b1;
        run_ticks(20, B_NONE, f, ff);
        checks++;
        if (game_state !== 2'b10 || f != 0) begin
            errors++;
            $display("FAIL pause_frozen: state=%b fires=%0d, required 10 and 0", game_state, f);
        end
        self_hit = 1'b0;
        press_pause();
        checks++;
        if (game_state !== 2'b01) begin
            errors++;
            $display("FAIL pause_exit: state=%b, required 01", game_state);
        end
        exp_q.push_back(D_RIGHT);
        run_ticks(5, B_NONE, f, ff);
        checks++;
        if (f != 1 || ff != 5) begin
            errors++;
            $display("FAIL pause_resume: fires=%0d at tick %0d, required 1 at tick 5", f, ff);
        end
`else
        checks++;
        if (game_state !== 2'b01) begin
            errors++;
            $display("FAIL no_pause: state=%b, required 01", game_state);
        end
        exp_q.push_back(D_RIGHT);
        run_ticks(5, B_NONE, f, ff);
        checks++;
        if (f != 1 || ff != 5) begin
            errors++;
            $display("FAIL no_pause_timing: fires=%0d at tick %0d, required 1 at tick 5", f, ff);
        end
`endif
    endtask

    task automatic test_reset_mid();
        checks++;
        if (game_state !== 2'b01) begin
            errors++;
            $display("FAIL mid_pre: state=%b, required 01", game_state);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (game_state !== 2'b00 || direction !== D_IDLE || score !== 8'd0 || update !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: state=%b dir=%b score=%0d upd=%b, required 00 000 0 0", game_state, direction, score, update);
        end
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_start();
        test_move_timing();
        test_steering();
        test_wall();
        test_food();
        test_pause();
        test_reset_mid();
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d expected moves never seen, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Game sequencer for the snake datapath.
- Turns button presses and per-frame ticks into the `direction`, `update` and `game_state` signals that drive the snake position/body registers.
- Detects wall and self collisions, counts food.
- Sits between the input synchronizers/VGA timing generator and the snake drawing block.

Parameters:
- BIT, 10, width of the pixel coordinates.
- SIZE, 5, snake segment size and step per move, in pixels.
- X_MAX, 640, visible width in pixels.
- Y_MAX, 480, visible height in pixels.
- FRAME_DIV, 8, number of frame_tick pulses per snake move (range 1..255).
- GAMEOVER_FRAMES, 60, number of frame_tick pulses spent in GAME_OVER (range 1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- frame_tick  in  1  one-cycle pulse once per video frame.
- btn_up, btn_down, btn_left, btn_right  in  1 each  synchronized, debounced button levels.
- btn_pause  in  1  pause toggle button level (used only with the optional feature).
- head_x, head_y  in  BIT each  current snake head position.
- food_hit  in  1  one-cycle pulse when the head eats food.
- self_hit  in  1  head overlaps body.
- direction  out  3  000 IDLE, 001 UP, 010 DOWN, 011 LEFT, 100 RIGHT.
- game_state  out  2  00 IDLE, 01 PLAY, 10 PAUSE, 11 GAME_OVER.
- update  out  1  one-cycle move strobe.
- score  out  8  food eaten in the current game.

Behaviour:
- Reset (async assert, sync release): game_state=IDLE, direction=IDLE, pending_dir=IDLE, update=0, score=0, frame counter=0, check=0.
- Button press = rising edge of a button level; edges are registered internally.
- Simultaneous presses: priority UP > DOWN > LEFT > RIGHT.
- IDLE:
  - First press → PLAY on the next edge.
  - direction and pending_dir load the pressed direction; score clears to 0; frame counter clears.
- PLAY, steering:
  - A press updates pending_dir.
  - The press is ignored if it is the reverse of the current direction, e.g. LEFT while moving RIGHT.
- PLAY, move timing:
  - The frame counter increments on each frame_tick.
  - On the frame_tick where counter == FRAME_DIV-1: counter → 0, update=1 for exactly one cycle, and direction ← registered pending_dir on that same edge, so direction is stable while update is high.
  - A press in the same cycle as the committing frame_tick affects the following move only.
- PLAY, collision check:
  - check is update delayed one cycle (the head register has moved by then).
  - While check=1, head_x > X_MAX-SIZE or head_y > Y_MAX-SIZE (unsigned, so underflow counts as out of bounds) → GAME_OVER.
  - self_hit=1 in any PLAY cycle → GAME_OVER.
- food_hit in PLAY: score+1, saturating at 255. This also applies in the same cycle as a collision.
- Entering GAME_OVER: direction=IDLE, update=0, frame counter=0, score held.
- GAME_OVER:
  - Buttons are ignored; frame_tick pulses are counted.
  - After GAMEOVER_FRAMES ticks → IDLE; score is held until the next game starts.
- update is never asserted outside PLAY.
- reset asserted mid-game: all state returns to reset values immediately.

Optional Feature:
- Macro SNAKE_GAME_PAUSE_EN.
- When defined:
  - A btn_pause rising edge in PLAY → PAUSE; in PAUSE → PLAY.
  - In PAUSE the frame counter, pending_dir and direction are frozen; update=0; steering and food_hit are ignored.
  - self_hit is ignored in PAUSE.
- When undefined: btn_pause is unused and the PAUSE encoding never occurs.

Decomposition:
- Shared package snake_pkg holds:
  - the direction encodings and game_state encodings;
  - an opposite-direction function.
- The snake drawing block and this block both use these definitions.
- One sub-module, snake_move_timer: a frame_tick divider with clear and enable inputs that outputs the move pulse. It is instantiated twice: once with FRAME_DIV for moves, once with GAMEOVER_FRAMES for the game-over hold.

Test Plan:
- Reset low, then high; pulse btn_right → next cycle game_state=01, direction=100, score=0.
- FRAME_DIV=8, PLAY: 16 frame_ticks → exactly 2 update pulses, each on the edge of the 8th/16th tick. Press UP between them → direction=001 only at the 2nd update.
- Moving RIGHT, press LEFT → direction stays 100 at the next update. Press DOWN and LEFT together → pending=DOWN.
- head_x=640 while check=1 → game_state=11, direction=000. After 60 frame_ticks → game_state=00, score unchanged.
- 300 food_hit pulses in PLAY → score=255. self_hit and food_hit in the same cycle → game_state=11 and score incremented.
- SNAKE_GAME_PAUSE_EN: btn_pause in PLAY → game_state=10. 20 frame_ticks → no update and self_hit ignored. btn_pause again → 01, and the counter resumes from its frozen value.
